// File: rtl/edge_binarizer.sv
// Binarizes the Sobel edge-magnitude stream and tracks raster position and per-frame edge count.
// Define EDGE_BINARIZER_ADAPTIVE_EN to derive the threshold from the previous frame's mean.
module edge_binarizer #(
  parameter int unsigned PIXEL_WIDTH    = 8,
  parameter int unsigned IMAGE_WIDTH    = 8,
  parameter int unsigned IMAGE_HEIGHT   = 8,
  parameter int unsigned INIT_THRESHOLD = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [PIXEL_WIDTH-1:0]                         edge_in,
  input  logic                                           valid_in,
  input  logic [PIXEL_WIDTH-1:0]                         thresh_static,
  input  logic [PIXEL_WIDTH-1:0]                         thresh_offset,
  input  logic                                           frame_restart,
  output logic [PIXEL_WIDTH-1:0]                         bin_out,
  output logic                                           valid_out,
  output logic [$clog2(IMAGE_WIDTH)-1:0]                 x_out,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]                y_out,
  output logic                                           frame_done,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT):0]      edge_count,
  output logic [PIXEL_WIDTH-1:0]                         threshold_out
);

  localparam int unsigned XW   = $clog2(IMAGE_WIDTH);
  localparam int unsigned YW   = $clog2(IMAGE_HEIGHT);
  localparam int unsigned NLOG = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam int unsigned CW   = NLOG + 1;

  if ((IMAGE_WIDTH < 2) || ((IMAGE_WIDTH & (IMAGE_WIDTH - 1)) != 0)) begin : g_bad_width
    $error("IMAGE_WIDTH must be a power of two >= 2");
  end
  if ((IMAGE_HEIGHT < 2) || ((IMAGE_HEIGHT & (IMAGE_HEIGHT - 1)) != 0)) begin : g_bad_height
    $error("IMAGE_HEIGHT must be a power of two >= 2");
  end

  logic [XW-1:0]          x_q, x_d, x_out_q, x_out_d;
  logic [YW-1:0]          y_q, y_d, y_out_q, y_out_d;
  logic [CW-1:0]          run_count_q, run_count_d, edge_count_q, edge_count_d;
  logic [PIXEL_WIDTH-1:0] bin_q, bin_d;
  logic                   valid_q, valid_d, frame_done_q, frame_done_d;
  logic [PIXEL_WIDTH-1:0] thr;
  logic                   is_edge, last_pixel;

  assign is_edge    = (edge_in >= thr);
  assign last_pixel = (x_q == XW'(IMAGE_WIDTH - 1)) && (y_q == YW'(IMAGE_HEIGHT - 1));

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    run_count_d  = run_count_q;
    edge_count_d = edge_count_q;
    bin_d        = bin_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    if (frame_restart) begin
      // A pixel coinciding with restart is dropped, not counted.
      x_d         = '0;
      y_d         = '0;
      run_count_d = '0;
    end else if (valid_in) begin
      x_d = x_q + XW'(1);
      if (x_q == XW'(IMAGE_WIDTH - 1)) begin
        y_d = y_q + YW'(1);
      end
      bin_d        = is_edge ? '1 : '0;
      x_out_d      = x_q;
      y_out_d      = y_q;
      valid_d      = 1'b1;
      frame_done_d = last_pixel;
      if (last_pixel) begin
        edge_count_d = run_count_q + CW'(is_edge);
        run_count_d  = '0;
      end else begin
        run_count_d = run_count_q + CW'(is_edge);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      run_count_q  <= '0;
      edge_count_q <= '0;
      bin_q        <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      run_count_q  <= run_count_d;
      edge_count_q <= edge_count_d;
      bin_q        <= bin_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef EDGE_BINARIZER_ADAPTIVE_EN
  localparam int unsigned SW = PIXEL_WIDTH + NLOG;

  logic [SW-1:0]          run_sum_q, run_sum_d, sum_all;
  logic [PIXEL_WIDTH-1:0] thr_q, thr_d, mean;
  logic [PIXEL_WIDTH:0]   thr_sum;
  logic                   unused_static;

  assign unused_static = ^thresh_static;
  assign thr           = thr_q;
  assign sum_all       = run_sum_q + SW'(edge_in);
  assign mean          = sum_all[SW-1:NLOG];
  assign thr_sum       = {1'b0, mean} + {1'b0, thresh_offset};

  always_comb begin
    run_sum_d = run_sum_q;
    thr_d     = thr_q;
    if (frame_restart) begin
      run_sum_d = '0;
    end else if (valid_in) begin
      if (last_pixel) begin
        run_sum_d = '0;
        thr_d     = thr_sum[PIXEL_WIDTH] ? '1 : thr_sum[PIXEL_WIDTH-1:0];
      end else begin
        run_sum_d = sum_all;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sum_q <= '0;
      thr_q     <= PIXEL_WIDTH'(INIT_THRESHOLD);
    end else begin
      run_sum_q <= run_sum_d;
      thr_q     <= thr_d;
    end
  end
`else
  logic unused_offset;

  assign unused_offset = ^thresh_offset;
  assign thr           = thresh_static;
`endif

  assign bin_out       = bin_q;
  assign valid_out     = valid_q;
  assign x_out         = x_out_q;
  assign y_out         = y_out_q;
  assign frame_done    = frame_done_q;
  assign edge_count    = edge_count_q;
  assign threshold_out = thr;

endmodule

// File: tb/tb_edge_binarizer.sv
// Directed self-checking bench for edge_binarizer (static or adaptive build).
module tb_edge_binarizer;

`ifdef EDGE_BINARIZER_ADAPTIVE_EN
  localparam int T0 = 64;
`else
  localparam int T0 = 100;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] edge_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] thresh_static = 8'd100;
  logic [7:0] thresh_offset = 8'd8;
  logic       frame_restart = 1'b0;
  logic [7:0] bin_out;
  logic       valid_out;
  logic [2:0] x_out;
  logic [2:0] y_out;
  logic       frame_done;
  logic [6:0] edge_count;
  logic [7:0] threshold_out;

  int n_asserts = 0;
  int n_fail    = 0;

  edge_binarizer dut (
    .clk          (clk),
    .rst          (rst),
    .edge_in      (edge_in),
    .valid_in     (valid_in),
    .thresh_static(thresh_static),
    .thresh_offset(thresh_offset),
    .frame_restart(frame_restart),
    .bin_out      (bin_out),
    .valid_out    (valid_out),
    .x_out        (x_out),
    .y_out        (y_out),
    .frame_done   (frame_done),
    .edge_count   (edge_count),
    .threshold_out(threshold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [7:0] e, input logic r);
    valid_in      = v;
    edge_in       = e;
    frame_restart = r;
    @(posedge clk);
    #1;
    valid_in      = 1'b0;
    frame_restart = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_pix(input string tag, input int i, input logic [7:0] bin);
    chk({tag, " valid"}, 32'(valid_out), 32'd1);
    chk({tag, " x"}, 32'(x_out), 32'(i % 8));
    chk({tag, " y"}, 32'(y_out), 32'(i / 8));
    chk({tag, " bin"}, 32'(bin_out), 32'(bin));
    chk({tag, " frame_done"}, 32'(frame_done), 32'(i == 63));
  endtask

  initial begin
    int gaps;
    logic [7:0] e;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst bin", 32'(bin_out), 32'd0);
    chk("rst valid", 32'(valid_out), 32'd0);
    chk("rst x", 32'(x_out), 32'd0);
    chk("rst y", 32'(y_out), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst edge_count", 32'(edge_count), 32'd0);
    chk("rst threshold", 32'(threshold_out), 32'(T0));
    rst = 1'b0;

    // Threshold boundary: below, equal, above
    step(1'b1, 8'(T0 - 1), 1'b0);
    chk("thr-1 bin", 32'(bin_out), 32'd0);
    chk("thr-1 valid", 32'(valid_out), 32'd1);
    chk("thr-1 x", 32'(x_out), 32'd0);
    step(1'b1, 8'(T0), 1'b0);
    chk("thr bin", 32'(bin_out), 32'd255);
    chk("thr x", 32'(x_out), 32'd1);
    step(1'b1, 8'(T0 + 1), 1'b0);
    chk("thr+1 bin", 32'(bin_out), 32'd255);
    chk("thr+1 x", 32'(x_out), 32'd2);
    step(1'b0, 8'd0, 1'b0);
    chk("idle valid", 32'(valid_out), 32'd0);
    chk("idle bin hold", 32'(bin_out), 32'd255);
    chk("idle x hold", 32'(x_out), 32'd2);

    // Asynchronous reset mid-frame
    #3 rst = 1'b1;
    #1;
    chk("midrst bin", 32'(bin_out), 32'd0);
    chk("midrst x", 32'(x_out), 32'd0);
    chk("midrst valid", 32'(valid_out), 32'd0);
    chk("midrst threshold", 32'(threshold_out), 32'(T0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'd0, 1'b0);
    chk("post-rst x", 32'(x_out), 32'd0);
    chk("post-rst y", 32'(y_out), 32'd0);
    chk("post-rst valid", 32'(valid_out), 32'd1);
    pulse_reset();

    // Gapped 8x8 frame, 10 edge pixels (every 7th)
    for (int i = 0; i < 64; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 8'd0, 1'b0);
        chk("gap valid", 32'(valid_out), 32'd0);
        chk("gap frame_done", 32'(frame_done), 32'd0);
      end
      e = (i % 7 == 0) ? 8'd200 : 8'd50;
      step(1'b1, e, 1'b0);
      chk_pix("gapped", i, (i % 7 == 0) ? 8'd255 : 8'd0);
      chk("gapped edge_count", 32'(edge_count), (i == 63) ? 32'd10 : 32'd0);
    end
`ifdef EDGE_BINARIZER_ADAPTIVE_EN
    // mean = (10*200 + 54*50) >> 6 = 73, plus offset 8
    chk("adapt thr after gapped", 32'(threshold_out), 32'd81);
`endif

    // frame_restart together with a valid pixel after 20 pixels
    for (int i = 0; i < 20; i++) step(1'b1, 8'd200, 1'b0);
    chk("pre-restart x", 32'(x_out), 32'd3);
    chk("pre-restart y", 32'(y_out), 32'd2);
    step(1'b1, 8'd200, 1'b1);
    chk("restart valid", 32'(valid_out), 32'd0);
    chk("restart frame_done", 32'(frame_done), 32'd0);
    chk("restart edge_count", 32'(edge_count), 32'd10);
    chk("restart x hold", 32'(x_out), 32'd3);

    // Back-to-back frames at full rate: all 40, then all 255
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'd40, 1'b0);
      chk_pix("frame40", i, 8'd0);
      chk("frame40 edge_count", 32'(edge_count), (i == 63) ? 32'd0 : 32'd10);
`ifdef EDGE_BINARIZER_ADAPTIVE_EN
      chk("frame40 threshold", 32'(threshold_out), (i == 63) ? 32'd48 : 32'd81);
`else
      chk("frame40 threshold", 32'(threshold_out), 32'd100);
`endif
    end
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'd255, 1'b0);
      chk_pix("frame255", i, 8'd255);
      chk("frame255 edge_count", 32'(edge_count), (i == 63) ? 32'd64 : 32'd0);
`ifdef EDGE_BINARIZER_ADAPTIVE_EN
      chk("frame255 threshold", 32'(threshold_out), (i == 63) ? 32'd255 : 32'd48);
`else
      chk("frame255 threshold", 32'(threshold_out), 32'd100);
`endif
    end
    step(1'b0, 8'd0, 1'b0);
    chk("final valid", 32'(valid_out), 32'd0);
    chk("final frame_done", 32'(frame_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_binarizer.md
# edge_binarizer

Downstream stage of the Sobel edge filter. Consumes the 8-bit saturated edge-magnitude stream and emits a binary edge map (0 or full-scale) with a 1-cycle registered latency. It tracks raster position, counts edge pixels per frame, and (optionally) adapts its threshold to the previous frame's mean magnitude.

## Interface
- PIXEL_WIDTH, 8, magnitude and output pixel width
- IMAGE_WIDTH, 8, pixels per line; power of two, ≥2
- IMAGE_HEIGHT, 8, lines per frame; power of two, ≥2
- INIT_THRESHOLD, 64, threshold used after reset, until the first adaptive update
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- edge_in  input  PIXEL_WIDTH  edge magnitude from the Sobel stage
- valid_in  input  1  edge_in valid this cycle; no backpressure
- thresh_static  input  PIXEL_WIDTH  fixed threshold (used when adaptation is compiled out)
- thresh_offset  input  PIXEL_WIDTH  unsigned offset added to frame mean
- frame_restart  input  1  synchronous pulse; discards the current partial frame
- bin_out  output  PIXEL_WIDTH  all-ones if edge, else 0
- valid_out  output  1  bin_out valid
- x_out  output  $clog2(IMAGE_WIDTH)  column of bin_out
- y_out  output  $clog2(IMAGE_HEIGHT)  line of bin_out
- frame_done  output  1  1-cycle pulse with the last pixel of a frame
- edge_count  output  $clog2(W*H)+1  edge pixels in the last completed frame
- threshold_out  output  PIXEL_WIDTH  threshold currently applied

## Operation
- Counters x, y start at 0. Each valid_in increments x; at W-1, x wraps to 0 and y increments; at (W-1, H-1) both wrap (end of frame).
- Edge decision: edge_in ≥ current threshold → bin_out = {PIXEL_WIDTH{1}}, else 0. Equality counts as an edge.
- Frame accumulators: run_count (edge pixels) and run_sum (Σ edge_in, width PIXEL_WIDTH+$clog2(W*H)). Both update on each valid pixel.
- End of frame (valid last pixel): edge_count ← run_count including that pixel; accumulators clear to 0. The new threshold is latched on the same edge and is first used on the next frame's pixel (0,0).
- Threshold update (adaptive build only): mean = (run_sum + edge_in) >> $clog2(W*H); thr = mean + thresh_offset, saturated to 2^PIXEL_WIDTH−1.
- frame_restart: x, y, run_count, run_sum ← 0; threshold and edge_count are held; no frame_done. If asserted together with valid_in, the pixel is discarded (no valid_out, not counted).
- valid_in low: outputs other than valid_out/frame_done hold their values; nothing advances.
- An elaboration-time check fails if W or H is not a power of two.

## Timing
- Latency is 1 cycle: bin_out, x_out, y_out and valid_out register the pixel accepted in the previous cycle.
- frame_done is high in the same cycle as valid_out for pixel (W-1, H-1). edge_count updates in that same cycle.
- Sustained throughput is 1 pixel/cycle, with no gaps needed between frames.
- Reset values: bin_out 0, valid_out 0, x_out 0, y_out 0, frame_done 0, edge_count 0, threshold_out INIT_THRESHOLD. Internal counters and accumulators are 0.
- Reset asserted mid-frame aborts the frame immediately. After deassertion, the next valid pixel is (0,0).

## Configuration
- EDGE_BINARIZER_ADAPTIVE_EN defined: threshold starts at INIT_THRESHOLD and updates each frame end by the mean+offset rule. thresh_static is ignored.
- Not defined: threshold_out = thresh_static, sampled each cycle. run_sum and the mean logic are absent, and thresh_offset is ignored. Counting and frame_done are unchanged.

## Test plan
- Reset: assert rst mid-frame → all outputs return to reset values. The next pixel emits with x_out=0 and y_out=0.
- Static build, thresh_static=100, inputs 99, 100, 101 → bin_out 0, 255, 255, each one cycle after its valid_in.
- 8×8 frame with valid_in gapped randomly, 10 pixels ≥ threshold → exactly one frame_done, on (7,7), with edge_count=10. Coordinates wrap correctly at each line.
- Adaptive build, offset=8: frame of all 40 → threshold_out=48 starting at next frame pixel (0,0), not at the last pixel. A frame of all 255 with offset 8 → threshold saturates at 255.
- frame_restart after 20 pixels, together with a valid pixel → that pixel produces no output. The next pixel is (0,0), with no frame_done and edge_count unchanged.
- Back-to-back frames at full rate → frame_done every 64 valid cycles, with no pixel dropped.
